// File: rtl/frida_pkg.sv
// rtl/frida_pkg.sv - shared mode encodings, scheduler state type and array defaults
package frida_pkg;

  localparam int N_ADC_DEF = 16;
  localparam int SEL_W_DEF = 4;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_FIXED = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_SWEEP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/adc_mux_scheduler_if.sv
// rtl/adc_mux_scheduler_if.sv - config, strobe and mux/enable signals between core logic and scheduler
interface adc_mux_scheduler_if #(
  parameter int N_ADC = 16,
  parameter int SEL_W = 4,
  parameter int CNT_W = 8
);

  logic [N_ADC-1:0] adc_en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] fixed_sel;
  logic [CNT_W-1:0] dwell;
  logic             start;
  logic             stop;
  logic             conv_done;
  logic [SEL_W-1:0] mux_sel;
  logic [N_ADC-1:0] adc_active;
  logic             data_valid;
  logic             frame_start;
  logic             sweep_done;
  logic             busy;
  logic             err_none;

  modport master (
    output adc_en, mode, fixed_sel, dwell, start, stop, conv_done,
    input  mux_sel, adc_active, data_valid, frame_start, sweep_done, busy, err_none
  );

  modport slave (
    input  adc_en, mode, fixed_sel, dwell, start, stop, conv_done,
    output mux_sel, adc_active, data_valid, frame_start, sweep_done, busy, err_none
  );

endinterface

// File: rtl/next_enabled_idx.sv
// rtl/next_enabled_idx.sv - rotate-priority search for the next set mask bit strictly after cur
module next_enabled_idx #(
  parameter int N_ADC = 16,
  parameter int SEL_W = 4
) (
  input  logic [N_ADC-1:0] mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrapped,
  output logic             any
);

  logic [SEL_W:0] sum;

  // Walk offsets from farthest to nearest so the nearest hit wins; carry out of sum marks a wrap.
  always_comb begin
    nxt     = cur;
    wrapped = 1'b0;
    any     = |mask;
    sum     = '0;
    for (int i = N_ADC; i >= 1; i--) begin
      sum = {1'b0, cur} + (SEL_W + 1)'(i);
      if (mask[sum[SEL_W-1:0]]) begin
        nxt     = sum[SEL_W-1:0];
        wrapped = sum[SEL_W];
      end
    end
  end

endmodule

// File: rtl/adc_mux_scheduler.sv
// rtl/adc_mux_scheduler.sv - dwell/scan sequencer for the comparator mux and per-ADC clock enables
module adc_mux_scheduler
  import frida_pkg::*;
#(
  parameter int N_ADC      = N_ADC_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input logic             clk,
  input logic             reset_b,
  adc_mux_scheduler_if.slave bus
);

  localparam int STW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam state_t ST_ENTER = (SETTLE_CYC == 0) ? ST_RUN : ST_SETTLE;
  localparam logic [STW-1:0] SETTLE_LAST = (SETTLE_CYC > 0) ? STW'(SETTLE_CYC - 1) : '0;
  localparam logic [N_ADC-1:0] ONE = {{(N_ADC-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [SEL_W-1:0] idx, idx_d;
  logic [N_ADC-1:0] active, active_d;
  logic [STW-1:0]   settle_cnt, settle_cnt_d;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_d;
  logic             first, first_d;
  logic             stop_pend, stop_pend_d;
  logic [N_ADC-1:0] sh_en, sh_en_d;
  logic [1:0]       sh_mode, sh_mode_d;
  logic [CNT_W-1:0] sh_dwell, sh_dwell_d;
  logic             frame_q, frame_d;
  logic             sweep_q, sweep_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] first_idx, nxt_idx;
  logic             first_any, nxt_wrap;
  logic             first_wrap_unused, nxt_any_unused;
  logic [CNT_W-1:0] dwell_eff;
  logic             dwell_hit, stop_eff;

  // First-index search starts "after" the top slot so bit 0 is examined first.
  next_enabled_idx #(.N_ADC(N_ADC), .SEL_W(SEL_W)) u_first (
    .mask(bus.adc_en), .cur({SEL_W{1'b1}}),
    .nxt(first_idx), .wrapped(first_wrap_unused), .any(first_any)
  );

  next_enabled_idx #(.N_ADC(N_ADC), .SEL_W(SEL_W)) u_next (
    .mask(sh_en), .cur(idx),
    .nxt(nxt_idx), .wrapped(nxt_wrap), .any(nxt_any_unused)
  );

  assign dwell_eff = (sh_dwell == '0) ? CNT_W'(1) : sh_dwell;
  assign dwell_hit = (dwell_cnt + CNT_W'(1)) == dwell_eff;
  assign stop_eff  = bus.stop || stop_pend;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state      <= ST_IDLE;
      idx        <= '0;
      active     <= '0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      first      <= 1'b0;
      stop_pend  <= 1'b0;
      sh_en      <= '0;
      sh_mode    <= MODE_IDLE;
      sh_dwell   <= '0;
      frame_q    <= 1'b0;
      sweep_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      active     <= active_d;
      settle_cnt <= settle_cnt_d;
      dwell_cnt  <= dwell_cnt_d;
      first      <= first_d;
      stop_pend  <= stop_pend_d;
      sh_en      <= sh_en_d;
      sh_mode    <= sh_mode_d;
      sh_dwell   <= sh_dwell_d;
      frame_q    <= frame_d;
      sweep_q    <= sweep_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    active_d     = active;
    settle_cnt_d = settle_cnt;
    dwell_cnt_d  = dwell_cnt;
    first_d      = first;
    stop_pend_d  = stop_pend;
    sh_en_d      = sh_en;
    sh_mode_d    = sh_mode;
    sh_dwell_d   = sh_dwell;
    frame_d      = 1'b0;
    sweep_d      = 1'b0;
    err_d        = err_q;

    case (state)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (bus.start && bus.mode != MODE_IDLE) begin
          if (bus.mode != MODE_FIXED && !first_any) begin
            err_d = 1'b1;
          end else begin
            err_d        = 1'b0;
            sh_en_d      = bus.adc_en;
            sh_mode_d    = bus.mode;
            sh_dwell_d   = bus.dwell;
            idx_d        = (bus.mode == MODE_FIXED) ? bus.fixed_sel : first_idx;
            active_d     = ONE << idx_d;
            state_d      = ST_ENTER;
            settle_cnt_d = '0;
            dwell_cnt_d  = '0;
            first_d      = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (stop_eff) begin
          state_d     = ST_IDLE;
          active_d    = '0;
          stop_pend_d = 1'b0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt + STW'(1);
        end
      end

      ST_RUN: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (bus.conv_done) begin
          frame_d     = first;
          first_d     = 1'b0;
          dwell_cnt_d = dwell_cnt + CNT_W'(1);
          if (dwell_hit) begin
            dwell_cnt_d = '0;
            if (sh_mode == MODE_FIXED) begin
              first_d = 1'b1;
            end else if (sh_mode == MODE_SWEEP && nxt_wrap) begin
              sweep_d  = 1'b1;
              state_d  = ST_IDLE;
              active_d = '0;
            end else begin
              sweep_d = nxt_wrap;
              first_d = 1'b1;
              if (nxt_idx != idx) begin
                idx_d        = nxt_idx;
                active_d     = ONE << nxt_idx;
                state_d      = ST_ENTER;
                settle_cnt_d = '0;
              end
            end
          end
          // Stop overrides any advance but keeps the mux on the ADC that just finished.
          if (stop_eff) begin
            state_d     = ST_IDLE;
            idx_d       = idx;
            active_d    = '0;
            stop_pend_d = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mux_sel     = idx;
  assign bus.adc_active  = active;
  assign bus.data_valid  = (state == ST_RUN);
  assign bus.frame_start = frame_q;
  assign bus.sweep_done  = sweep_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.err_none    = err_q;

endmodule

// File: tb/tb_adc_mux_scheduler.sv
// tb/tb_adc_mux_scheduler.sv - directed bench with frame scoreboard for adc_mux_scheduler
module tb_adc_mux_scheduler;
  import frida_pkg::*;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int frames = 0;
  int exp_q[$];
  logic [3:0] sel_prev = '0;
  int scan_seq[4] = '{0, 5, 10, 15};

  adc_mux_scheduler_if #(.N_ADC(16), .SEL_W(4), .CNT_W(8)) bus ();

  adc_mux_scheduler #(.N_ADC(16), .SEL_W(4), .CNT_W(8), .SETTLE_CYC(2)) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each frame_start must name the ADC that was selected while its strobe was present.
  always @(negedge clk) begin
    if (reset_b && bus.frame_start) begin
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
      frames++;
      check("frame_sel", 32'(sel_prev), 32'(e));
    end
    sel_prev = bus.mux_sel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel);
    exp_q.push_back(sel);
    pushes++;
  endtask

  task automatic set_cfg(input logic [15:0] en, input logic [1:0] md, input logic [3:0] fs, input logic [7:0] dw);
    bus.adc_en = en;
    bus.mode = md;
    bus.fixed_sel = fs;
    bus.dwell = dw;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic do_conv();
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20 && !bus.data_valid; i++) tick();
    check("run_reached", 32'(bus.data_valid), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mux"}, 32'(bus.mux_sel), 32'd0);
    check({tag, "_active"}, 32'(bus.adc_active), 32'd0);
    check({tag, "_flags"}, 32'({bus.data_valid, bus.frame_start, bus.sweep_done, bus.busy, bus.err_none}), 32'd0);
  endtask

  initial begin
    set_cfg(16'h0, MODE_IDLE, 4'd0, 8'd0);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.conv_done = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset_b = 1'b1;
    tick();

    // Scan over 0,5,10,15 with a blanked strobe during the first settle.
    set_cfg(16'h8421, MODE_SCAN, 4'd0, 8'd2);
    pulse_start();
    check("scan_first_sel", 32'(bus.mux_sel), 32'd0);
    check("scan_first_active", 32'(bus.adc_active), 32'h0001);
    check("scan_settle_dv", 32'(bus.data_valid), 32'd0);
    do_conv();
    for (int k = 0; k < 4; k++) begin
      wait_run();
      push(scan_seq[k]);
      do_conv();
      check("scan_mid_busy", 32'(bus.busy), 32'd1);
      do_conv();
      if (k < 3) begin
        check("scan_switch_sel", 32'(bus.mux_sel), 32'(scan_seq[k+1]));
        check("scan_switch_dv", 32'(bus.data_valid), 32'd0);
        check("scan_no_sweep", 32'(bus.sweep_done), 32'd0);
      end else begin
        check("scan_wrap_sel", 32'(bus.mux_sel), 32'd0);
        check("scan_wrap_sweep", 32'(bus.sweep_done), 32'd1);
      end
    end

    // Reset while running on ADC 5.
    wait_run();
    push(0);
    do_conv();
    do_conv();
    wait_run();
    check("pre_reset_sel", 32'(bus.mux_sel), 32'd5);
    reset_b = 1'b0;
    tick();
    check_zero("midrun_reset");
    reset_b = 1'b1;
    tick();

    // Single sweep over 0,1 with dwell 0 acting as 1.
    set_cfg(16'h0003, MODE_SWEEP, 4'd0, 8'd0);
    pulse_start();
    wait_run();
    push(0);
    do_conv();
    check("sweep_sel1", 32'(bus.mux_sel), 32'd1);
    wait_run();
    push(1);
    do_conv();
    check("sweep_done", 32'(bus.sweep_done), 32'd1);
    check("sweep_busy", 32'(bus.busy), 32'd0);
    check("sweep_active", 32'(bus.adc_active), 32'd0);
    check("sweep_hold_sel", 32'(bus.mux_sel), 32'd1);

    // Fixed on ADC 9, dwell 3; config edits mid-run are ignored.
    set_cfg(16'h0000, MODE_FIXED, 4'd9, 8'd3);
    pulse_start();
    wait_run();
    for (int c = 0; c < 7; c++) begin
      if (c % 3 == 0) push(9);
      if (c == 2) set_cfg(16'hFFFF, MODE_SCAN, 4'd0, 8'd1);
      do_conv();
      check("fixed_sel", 32'(bus.mux_sel), 32'd9);
      check("fixed_active", 32'(bus.adc_active), 32'h0200);
    end
    pulse_stop();
    do_conv();
    check("fixed_stop_busy", 32'(bus.busy), 32'd0);
    check("fixed_stop_sel", 32'(bus.mux_sel), 32'd9);

    // No ADC enabled in scan mode, then recovery.
    set_cfg(16'h0000, MODE_SCAN, 4'd0, 8'd1);
    pulse_start();
    check("err_set", 32'(bus.err_none), 32'd1);
    check("err_busy", 32'(bus.busy), 32'd0);
    bus.adc_en = 16'h0001;
    pulse_start();
    check("err_clear", 32'(bus.err_none), 32'd0);
    check("err_recover_busy", 32'(bus.busy), 32'd1);
    pulse_stop();
    check("settle_stop_busy", 32'(bus.busy), 32'd0);
    check("settle_stop_active", 32'(bus.adc_active), 32'd0);

    bus.mode = MODE_IDLE;
    pulse_start();
    check("mode_idle_start", 32'(bus.busy), 32'd0);

    // Stop while running on ADC 4 of a scan.
    set_cfg(16'h0014, MODE_SCAN, 4'd0, 8'd2);
    pulse_start();
    wait_run();
    push(2);
    do_conv();
    do_conv();
    check("stop_scan_sel4", 32'(bus.mux_sel), 32'd4);
    wait_run();
    push(4);
    pulse_stop();
    check("stop_pending_busy", 32'(bus.busy), 32'd1);
    do_conv();
    check("stop_run_busy", 32'(bus.busy), 32'd0);
    check("stop_run_sel", 32'(bus.mux_sel), 32'd4);
    check("stop_run_active", 32'(bus.adc_active), 32'd0);

    // start and stop together in IDLE: start wins.
    set_cfg(16'h0000, MODE_FIXED, 4'd3, 8'd3);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    check("startstop_busy", 32'(bus.busy), 32'd1);
    check("startstop_sel", 32'(bus.mux_sel), 32'd3);
    wait_run();
    push(3);
    do_conv();
    check("startstop_still_busy", 32'(bus.busy), 32'd1);
    bus.fixed_sel = 4'd7;
    pulse_start();
    check("start_ignored_busy", 32'(bus.mux_sel), 32'd3);
    pulse_stop();
    do_conv();
    check("final_stop_busy", 32'(bus.busy), 32'd0);

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(frames), 32'(pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_mux_scheduler.md
Name: adc_mux_scheduler

Overview:
- Sequences the 16:1 comparator-output multiplexer and per-ADC sequencing-clock enables across the 4x4 ADC array inside frida_core.
- Dwells on one ADC for a programmed number of conversions, then advances to the next enabled ADC (fixed, continuous scan, or single sweep).
- Configuration comes from SPI register fields; conversion boundaries come from an end-of-conversion strobe already synchronised to clk.

Parameters:
N_ADC, 16, number of ADC instances (power of 2)
SEL_W, 4, mux select width = log2(N_ADC)
CNT_W, 8, width of dwell conversion counter
SETTLE_CYC, 2, clk cycles of mux settling after a switch; 0 allowed

Ports:
clk  in  1  scheduler clock (driven from seq_logic domain at core level)
reset_b  in  1  synchronous active-low reset
adc_en  in  N_ADC  per-ADC scan enable (SPI config)
mode  in  2  00 idle, 01 fixed, 10 continuous scan, 11 single sweep
fixed_sel  in  SEL_W  ADC index used in fixed mode
dwell  in  CNT_W  conversions per ADC; 0 treated as 1
start  in  1  single-cycle pulse, begins operation from IDLE
stop  in  1  single-cycle pulse, stop after current conversion
conv_done  in  1  single-cycle end-of-conversion strobe
mux_sel  out  SEL_W  comparator mux select
adc_active  out  N_ADC  one-hot sequencing-clock enable of selected ADC
data_valid  out  1  high when comp_out belongs to a fully settled conversion
frame_start  out  1  pulse: first valid conversion after each switch
sweep_done  out  1  pulse: last conversion of a sweep completed
busy  out  1  high in any state except IDLE
err_none  out  1  sticky: start seen with no enabled ADC in scan modes

Behaviour:
- Reset (reset_b=0 at clk edge): state IDLE, mux_sel=0, adc_active=0, data_valid=0, frame_start=0, sweep_done=0, busy=0, err_none=0; counters cleared. Reset wins over every other input, including mid-conversion.
- Shadow config: adc_en, mode, fixed_sel, dwell latched on accepted start only; changes during operation are ignored until next start.
- start ignored when not IDLE. start with mode=00: no action. err_none clears on next accepted start.
- States: IDLE -> SETTLE -> RUN -> (SETTLE | IDLE).
- IDLE + start: fixed: idx=fixed_sel; scan/sweep: idx=lowest enabled index; none enabled -> err_none=1, stay IDLE. Next cycle mux_sel=idx, adc_active=onehot(idx), enter SETTLE.
- SETTLE: count SETTLE_CYC cycles (SETTLE_CYC=0 -> directly RUN next cycle); data_valid=0; conv_done ignored (blanked, not counted).
- RUN: data_valid=1. Each conv_done increments dwell counter; first conv_done after entering RUN pulses frame_start same cycle (registered output, visible one cycle after strobe).
- Dwell reached (count == max(dwell,1)):
  - fixed: counter resets, stay RUN on same ADC (no switch, frame_start pulses again).
  - scan: next enabled index above idx, wrapping to lowest; if only one enabled, stay on it (frame_start pulses, no SETTLE). Switch -> SETTLE, mux_sel updates next cycle.
  - sweep: if idx was highest enabled -> sweep_done pulse, IDLE, adc_active=0; else advance as scan.
  - scan wrap (highest -> lowest) also pulses sweep_done.
- stop: registered as pending; at next conv_done in RUN (or immediately if in SETTLE) -> IDLE, adc_active=0, mux_sel holds last value. stop in IDLE ignored. stop and dwell-complete on same conv_done: go IDLE, sweep_done still pulses if applicable.
- start and stop same cycle in IDLE: start accepted, stop ignored.
- Latency: conv_done -> mux_sel change = 1 clk.

Decomposition:
- Package frida_pkg: mode encoding constants (MODE_IDLE/FIXED/SCAN/SWEEP), state enum, N_ADC/SEL_W defaults.
- Sub-module next_enabled_idx: combinational rotate-priority finder (inputs mask, current idx; outputs next idx, wrapped flag, any flag), reused for first-index search with idx=N_ADC-1.

Test Plan:
- Reset mid-RUN (mode=10, idx=5): assert reset_b=0 one cycle -> all outputs zero, busy=0 next edge.
- Scan adc_en=16'h8421, dwell=2, SETTLE_CYC=2: 8 conv_done after settles -> mux_sel 0,5,10,15, then 0 with sweep_done on wrap; conv_done during SETTLE not counted.
- Sweep adc_en=16'h0003, dwell=0: -> one conversion each on 0,1, sweep_done pulse, IDLE, adc_active=0.
- Fixed fixed_sel=9, dwell=3: -> mux_sel=9 permanently, frame_start every 3rd conv_done; adc_en changes mid-run have no effect.
- Scan adc_en=0 + start -> err_none=1, busy stays 0; next start with adc_en=1 clears err_none.
- stop during RUN on ADC 4 of scan -> IDLE on next conv_done, mux_sel stays 4; start+stop same cycle in IDLE -> busy=1.
